// File: rtl/integer_accumulator.sv
// Two-stage (capture, accumulate) consumer of typed-integer samples: signed running sums,
// enum histogram and X/Z bookkeeping, with saturating or wrapping adds.
module integer_accumulator #(
   parameter int unsigned SATURATE = 1,
   parameter int unsigned COUNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               clear,
   input  logic [31:0]        enum_in,
   input  logic [7:0]         byte_in,
   input  logic [15:0]        shortint_in,
   input  logic [31:0]        int_in,
   input  logic [63:0]        longint_in,
   input  logic [31:0]        integer_in,
   output logic [7:0]         byte_acc,
   output logic [15:0]        shortint_acc,
   output logic [31:0]        int_acc,
   output logic [63:0]        longint_acc,
   output logic [31:0]        integer_acc,
   output logic [4:0]         overflow,
   output logic [COUNT_W-1:0] count_a,
   output logic [COUNT_W-1:0] count_b,
   output logic [COUNT_W-1:0] count_c,
   output logic [COUNT_W-1:0] count_d,
   output logic [COUNT_W-1:0] count_invalid,
   output logic [COUNT_W-1:0] xz_count,
   output logic [COUNT_W-1:0] sample_count,
   output logic               acc_valid
);

   localparam logic [31:0] EnumA = 32'd0;
   localparam logic [31:0] EnumB = 32'd1;
   localparam logic [31:0] EnumC = 32'd45;
   localparam logic [31:0] EnumD = 32'd123789;

   localparam logic [COUNT_W-1:0] CntOne   = {{(COUNT_W-1){1'b0}}, 1'b1};
   localparam logic [COUNT_W-1:0] CntMaxM1 = {{(COUNT_W-1){1'b1}}, 1'b0};

   typedef enum logic [0:0] {StRun, StFull} state_e;

   // Signed add of two sign-extended w-bit operands; returns {overflow, result}.
   function automatic logic [64:0] add_w(input logic [63:0] a, input logic [63:0] b,
                                         input int unsigned w);
      logic signed [64:0] sum, max_v, min_v;
      logic [63:0]        res;
      logic               ovf;
      sum   = $signed({a[63], a}) + $signed({b[63], b});
      max_v = (65'sd1 <<< (w - 1)) - 65'sd1;
      min_v = -max_v - 65'sd1;
      ovf   = (sum > max_v) || (sum < min_v);
      res   = sum[63:0];
      if (ovf && (SATURATE != 0)) begin
         res = (sum > max_v) ? max_v[63:0] : min_v[63:0];
      end
      return {ovf, res};
   endfunction

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
      return (&c) ? c : c + CntOne;
   endfunction

   state_e              state_q, state_d;
   logic                s1_valid_q, s1_valid_d;
   logic [31:0]         s1_enum_q, s1_enum_d;
   logic [7:0]          s1_byte_q, s1_byte_d;
   logic [15:0]         s1_short_q, s1_short_d;
   logic [31:0]         s1_int_q, s1_int_d;
   logic [63:0]         s1_long_q, s1_long_d;
   logic [31:0]         s1_integer_q, s1_integer_d;
   logic                s1_xz_q, s1_xz_d;
   logic [7:0]          byte_acc_q, byte_acc_d;
   logic [15:0]         short_acc_q, short_acc_d;
   logic [31:0]         int_acc_q, int_acc_d;
   logic [63:0]         long_acc_q, long_acc_d;
   logic [31:0]         integer_acc_q, integer_acc_d;
   logic [4:0]          overflow_q, overflow_d;
   logic [COUNT_W-1:0]  count_a_q, count_a_d, count_b_q, count_b_d;
   logic [COUNT_W-1:0]  count_c_q, count_c_d, count_d_q, count_d_d;
   logic [COUNT_W-1:0]  count_inv_q, count_inv_d, xz_count_q, xz_count_d;
   logic [COUNT_W-1:0]  sample_count_q, sample_count_d;
   logic                acc_valid_q, acc_valid_d;

   logic                accept, int_par, in_xz;
   logic [64:0]         r_byte, r_short, r_int, r_long, r_integer;
   logic                unused_add;

   assign in_ready = (state_q == StRun) && !clear;
   assign accept   = in_valid && in_ready;

   // Any X/Z bit makes the parity neither 0 nor 1.
   assign int_par = ^integer_in;
   assign in_xz   = !((int_par === 1'b0) || (int_par === 1'b1));

   assign r_byte    = add_w({{56{byte_acc_q[7]}}, byte_acc_q},
                            {{56{s1_byte_q[7]}}, s1_byte_q}, 8);
   assign r_short   = add_w({{48{short_acc_q[15]}}, short_acc_q},
                            {{48{s1_short_q[15]}}, s1_short_q}, 16);
   assign r_int     = add_w({{32{int_acc_q[31]}}, int_acc_q},
                            {{32{s1_int_q[31]}}, s1_int_q}, 32);
   assign r_long    = add_w(long_acc_q, s1_long_q, 64);
   assign r_integer = add_w({{32{integer_acc_q[31]}}, integer_acc_q},
                            {{32{s1_integer_q[31]}}, s1_integer_q}, 32);
   assign unused_add = ^{r_byte[63:8], r_short[63:16], r_int[63:32], r_integer[63:32]};

   always_comb begin
      state_d        = state_q;
      s1_valid_d     = accept;
      s1_enum_d      = accept ? enum_in     : s1_enum_q;
      s1_byte_d      = accept ? byte_in     : s1_byte_q;
      s1_short_d     = accept ? shortint_in : s1_short_q;
      s1_int_d       = accept ? int_in      : s1_int_q;
      s1_long_d      = accept ? longint_in  : s1_long_q;
      s1_integer_d   = accept ? integer_in  : s1_integer_q;
      s1_xz_d        = accept ? in_xz       : s1_xz_q;
      byte_acc_d     = byte_acc_q;
      short_acc_d    = short_acc_q;
      int_acc_d      = int_acc_q;
      long_acc_d     = long_acc_q;
      integer_acc_d  = integer_acc_q;
      overflow_d     = overflow_q;
      count_a_d      = count_a_q;
      count_b_d      = count_b_q;
      count_c_d      = count_c_q;
      count_d_d      = count_d_q;
      count_inv_d    = count_inv_q;
      xz_count_d     = xz_count_q;
      sample_count_d = sample_count_q;
      acc_valid_d    = s1_valid_q;

      if (accept) begin
         sample_count_d = sat_inc(sample_count_q);
         if (sample_count_q == CntMaxM1) state_d = StFull;
      end

      if (s1_valid_q) begin
         byte_acc_d    = r_byte[7:0];
         short_acc_d   = r_short[15:0];
         int_acc_d     = r_int[31:0];
         long_acc_d    = r_long[63:0];
         overflow_d[0] = overflow_q[0] | r_byte[64];
         overflow_d[1] = overflow_q[1] | r_short[64];
         overflow_d[2] = overflow_q[2] | r_int[64];
         overflow_d[3] = overflow_q[3] | r_long[64];
         if (s1_xz_q) begin
            xz_count_d = sat_inc(xz_count_q);
         end else begin
            integer_acc_d = r_integer[31:0];
            overflow_d[4] = overflow_q[4] | r_integer[64];
         end
         case (s1_enum_q)
            EnumA:   count_a_d   = sat_inc(count_a_q);
            EnumB:   count_b_d   = sat_inc(count_b_q);
            EnumC:   count_c_d   = sat_inc(count_c_q);
            EnumD:   count_d_d   = sat_inc(count_d_q);
            default: count_inv_d = sat_inc(count_inv_q);
         endcase
      end

      if (clear) begin
         state_d        = StRun;
         s1_valid_d     = 1'b0;
         acc_valid_d    = 1'b0;
         byte_acc_d     = '0;
         short_acc_d    = '0;
         int_acc_d      = '0;
         long_acc_d     = '0;
         integer_acc_d  = '0;
         overflow_d     = '0;
         count_a_d      = '0;
         count_b_d      = '0;
         count_c_d      = '0;
         count_d_d      = '0;
         count_inv_d    = '0;
         xz_count_d     = '0;
         sample_count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StRun;
         s1_valid_q     <= 1'b0;
         s1_enum_q      <= '0;
         s1_byte_q      <= '0;
         s1_short_q     <= '0;
         s1_int_q       <= '0;
         s1_long_q      <= '0;
         s1_integer_q   <= '0;
         s1_xz_q        <= 1'b0;
         byte_acc_q     <= '0;
         short_acc_q    <= '0;
         int_acc_q      <= '0;
         long_acc_q     <= '0;
         integer_acc_q  <= '0;
         overflow_q     <= '0;
         count_a_q      <= '0;
         count_b_q      <= '0;
         count_c_q      <= '0;
         count_d_q      <= '0;
         count_inv_q    <= '0;
         xz_count_q     <= '0;
         sample_count_q <= '0;
         acc_valid_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         s1_valid_q     <= s1_valid_d;
         s1_enum_q      <= s1_enum_d;
         s1_byte_q      <= s1_byte_d;
         s1_short_q     <= s1_short_d;
         s1_int_q       <= s1_int_d;
         s1_long_q      <= s1_long_d;
         s1_integer_q   <= s1_integer_d;
         s1_xz_q        <= s1_xz_d;
         byte_acc_q     <= byte_acc_d;
         short_acc_q    <= short_acc_d;
         int_acc_q      <= int_acc_d;
         long_acc_q     <= long_acc_d;
         integer_acc_q  <= integer_acc_d;
         overflow_q     <= overflow_d;
         count_a_q      <= count_a_d;
         count_b_q      <= count_b_d;
         count_c_q      <= count_c_d;
         count_d_q      <= count_d_d;
         count_inv_q    <= count_inv_d;
         xz_count_q     <= xz_count_d;
         sample_count_q <= sample_count_d;
         acc_valid_q    <= acc_valid_d;
      end
   end

   assign byte_acc      = byte_acc_q;
   assign shortint_acc  = short_acc_q;
   assign int_acc       = int_acc_q;
   assign longint_acc   = long_acc_q;
   assign integer_acc   = integer_acc_q;
   assign overflow      = overflow_q;
   assign count_a       = count_a_q;
   assign count_b       = count_b_q;
   assign count_c       = count_c_q;
   assign count_d       = count_d_q;
   assign count_invalid = count_inv_q;
   assign xz_count      = xz_count_q;
   assign sample_count  = sample_count_q;
   assign acc_valid     = acc_valid_q;

endmodule

// File: tb/tb_integer_accumulator.sv
// Bench for integer_accumulator: saturating, wrapping and 4-bit-counter instances share
// one stimulus; table vectors feed a scoreboard, hand sequences cover pipeline corners.
module tb_integer_accumulator;

   localparam logic [63:0] LMax = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] LMin = 64'h8000_0000_0000_0000;

   logic        clk, rst, in_valid, clear;
   logic [31:0] enum_in, int_in, integer_in;
   logic [7:0]  byte_in;
   logic [15:0] shortint_in;
   logic [63:0] longint_in;

   logic        s_in_ready, s_acc_valid;
   logic [7:0]  s_byte;
   logic [15:0] s_short;
   logic [31:0] s_int, s_integer;
   logic [63:0] s_long;
   logic [4:0]  s_ovf;
   logic [15:0] s_ca, s_cb, s_cc, s_cd, s_ci, s_xz, s_sc;

   logic        w_in_ready, w_acc_valid;
   logic [7:0]  w_byte;
   logic [15:0] w_short;
   logic [31:0] w_int, w_integer;
   logic [63:0] w_long;
   logic [4:0]  w_ovf;
   logic [15:0] w_ca, w_cb, w_cc, w_cd, w_ci, w_xz, w_sc;

   logic        c_in_ready, c_acc_valid;
   logic [7:0]  c_byte;
   logic [15:0] c_short;
   logic [31:0] c_int, c_integer;
   logic [63:0] c_long;
   logic [4:0]  c_ovf;
   logic [3:0]  c_ca, c_cb, c_cc, c_cd, c_ci, c_xz, c_sc;

   integer_accumulator #(.SATURATE(1), .COUNT_W(16)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .clear(clear),
      .enum_in(enum_in), .byte_in(byte_in), .shortint_in(shortint_in), .int_in(int_in),
      .longint_in(longint_in), .integer_in(integer_in), .byte_acc(s_byte),
      .shortint_acc(s_short), .int_acc(s_int), .longint_acc(s_long), .integer_acc(s_integer),
      .overflow(s_ovf), .count_a(s_ca), .count_b(s_cb), .count_c(s_cc), .count_d(s_cd),
      .count_invalid(s_ci), .xz_count(s_xz), .sample_count(s_sc), .acc_valid(s_acc_valid)
   );

   integer_accumulator #(.SATURATE(0), .COUNT_W(16)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .clear(clear),
      .enum_in(enum_in), .byte_in(byte_in), .shortint_in(shortint_in), .int_in(int_in),
      .longint_in(longint_in), .integer_in(integer_in), .byte_acc(w_byte),
      .shortint_acc(w_short), .int_acc(w_int), .longint_acc(w_long), .integer_acc(w_integer),
      .overflow(w_ovf), .count_a(w_ca), .count_b(w_cb), .count_c(w_cc), .count_d(w_cd),
      .count_invalid(w_ci), .xz_count(w_xz), .sample_count(w_sc), .acc_valid(w_acc_valid)
   );

   integer_accumulator #(.SATURATE(1), .COUNT_W(4)) u_cw4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .clear(clear),
      .enum_in(enum_in), .byte_in(byte_in), .shortint_in(shortint_in), .int_in(int_in),
      .longint_in(longint_in), .integer_in(integer_in), .byte_acc(c_byte),
      .shortint_acc(c_short), .int_acc(c_int), .longint_acc(c_long), .integer_acc(c_integer),
      .overflow(c_ovf), .count_a(c_ca), .count_b(c_cb), .count_c(c_cc), .count_d(c_cd),
      .count_invalid(c_ci), .xz_count(c_xz), .sample_count(c_sc), .acc_valid(c_acc_valid)
   );

   typedef struct {
      logic [7:0]  b;  logic [15:0] s;  logic [31:0] i;  logic [63:0] l;  logic [31:0] g;
      logic [7:0]  sb; logic [15:0] ss; logic [31:0] si; logic [63:0] sl; logic [31:0] sg;
      logic [4:0]  sovf;
      logic [7:0]  wb; logic [63:0] wl; logic [4:0]  wovf;
   } vec_t;

   vec_t vecs[14];
   vec_t exp_q[$];
   int   n_checks = 0, n_fail = 0;
   int   sat_pulses = 0, cw4_pulses = 0;
   bit   sb_on = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] b, input logic [15:0] s, input logic [31:0] i,
                               input logic [63:0] l, input logic [31:0] g,
                               input logic [7:0] sb, input logic [15:0] ss,
                               input logic [31:0] si, input logic [63:0] sl,
                               input logic [31:0] sg, input logic [4:0] sovf,
                               input logic [7:0] wb, input logic [63:0] wl,
                               input logic [4:0] wovf);
      vec_t v;
      v.b = b; v.s = s; v.i = i; v.l = l; v.g = g;
      v.sb = sb; v.ss = ss; v.si = si; v.sl = sl; v.sg = sg; v.sovf = sovf;
      v.wb = wb; v.wl = wl; v.wovf = wovf;
      return v;
   endfunction

   // Scoreboard: pops one expected record per acc_valid pulse of the saturating instance.
   initial begin
      vec_t e;
      forever begin
         @(negedge clk);
         if (c_acc_valid) cw4_pulses++;
         if (s_acc_valid) begin
            sat_pulses++;
            if (sb_on) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_unexpected: acc_valid with no expected record");
               end else begin
                  e = exp_q.pop_front();
                  chk("sat_byte", s_byte, e.sb);
                  chk("sat_short", s_short, e.ss);
                  chk("sat_int", s_int, e.si);
                  chk("sat_long", s_long, e.sl);
                  chk("sat_integer", s_integer, e.sg);
                  chk("sat_ovf", s_ovf, e.sovf);
                  chk("wrap_byte", w_byte, e.wb);
                  chk("wrap_long", w_long, e.wl);
                  chk("wrap_ovf", w_ovf, e.wovf);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; clear = 0; enum_in = 0; byte_in = 0; shortint_in = 0;
      int_in = 0; longint_in = 0; integer_in = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   initial begin
      logic [31:0] xv;
      logic        is4;
      rst = 1;
      idle_inputs();
      tick();
      tick();
      rst = 0;
      repeat (5) tick();
      @(negedge clk);
      chk("rst_in_ready", s_in_ready, 1);
      chk("rst_acc_valid", s_acc_valid, 0);
      chk("rst_byte", s_byte, 0);
      chk("rst_long", s_long, 0);
      chk("rst_ovf", s_ovf, 0);
      chk("rst_sample_count", s_sc, 0);
      chk("rst_count_a", s_ca, 0);
      chk("rst_xz", s_xz, 0);

      //        b      s         i             l      g             | sat                                           | wrap
      vecs[0]  = mk(8'h64, 16'h0, 32'h0, 64'h0, 32'h0, 8'h64, 16'h0, 32'h0, 64'h0, 32'h0, 5'h00,
                    8'h64, 64'h0, 5'h00);
      vecs[1]  = mk(8'h64, 16'h0, 32'h0, 64'h0, 32'h0, 8'h7F, 16'h0, 32'h0, 64'h0, 32'h0, 5'h01,
                    8'hC8, 64'h0, 5'h01);
      vecs[2]  = mk(8'h80, 16'h0, 32'h0, 64'h0, 32'h0, 8'hFF, 16'h0, 32'h0, 64'h0, 32'h0, 5'h01,
                    8'h48, 64'h0, 5'h01);
      vecs[3]  = mk(8'h80, 16'h0, 32'h0, 64'h0, 32'h0, 8'h80, 16'h0, 32'h0, 64'h0, 32'h0, 5'h01,
                    8'hC8, 64'h0, 5'h01);
      vecs[4]  = mk(8'h80, 16'h0, 32'h0, 64'h0, 32'h0, 8'h80, 16'h0, 32'h0, 64'h0, 32'h0, 5'h01,
                    8'h48, 64'h0, 5'h01);
      vecs[5]  = mk(8'h00, 16'h7FFF, 32'h0, 64'h0, 32'h0, 8'h80, 16'h7FFF, 32'h0, 64'h0, 32'h0,
                    5'h01, 8'h48, 64'h0, 5'h01);
      vecs[6]  = mk(8'h00, 16'h0001, 32'h0, 64'h0, 32'h0, 8'h80, 16'h7FFF, 32'h0, 64'h0, 32'h0,
                    5'h03, 8'h48, 64'h0, 5'h03);
      vecs[7]  = mk(8'h00, 16'h0, 32'h8000_0000, 64'h0, 32'h0, 8'h80, 16'h7FFF, 32'h8000_0000,
                    64'h0, 32'h0, 5'h03, 8'h48, 64'h0, 5'h03);
      vecs[8]  = mk(8'h00, 16'h0, 32'hFFFF_FFFF, 64'h0, 32'h0, 8'h80, 16'h7FFF, 32'h8000_0000,
                    64'h0, 32'h0, 5'h07, 8'h48, 64'h0, 5'h07);
      vecs[9]  = mk(8'h00, 16'h0, 32'h0, LMax, 32'h0, 8'h80, 16'h7FFF, 32'h8000_0000, LMax,
                    32'h0, 5'h07, 8'h48, LMax, 5'h07);
      vecs[10] = mk(8'h00, 16'h0, 32'h0, 64'h1, 32'h0, 8'h80, 16'h7FFF, 32'h8000_0000, LMax,
                    32'h0, 5'h0F, 8'h48, LMin, 5'h0F);
      vecs[11] = mk(8'h01, 16'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 8'h81, 16'h7FFF,
                    32'h8000_0000, 64'h7FFF_FFFF_FFFF_FFFE, 32'h0, 5'h0F, 8'h49, LMax, 5'h0F);
      vecs[12] = mk(8'h00, 16'h0, 32'h0, 64'h0, 32'h8000_0000, 8'h81, 16'h7FFF, 32'h8000_0000,
                    64'h7FFF_FFFF_FFFF_FFFE, 32'h8000_0000, 5'h0F, 8'h49, LMax, 5'h0F);
      vecs[13] = mk(8'h00, 16'h0, 32'h0, 64'h0, 32'hFFFF_FFFF, 8'h81, 16'h7FFF, 32'h8000_0000,
                    64'h7FFF_FFFF_FFFF_FFFE, 32'h8000_0000, 5'h1F, 8'h49, LMax, 5'h1F);

      sat_pulses = 0;
      sb_on = 1;
      for (int k = 0; k < 14; k++) begin
         in_valid = 1; byte_in = vecs[k].b; shortint_in = vecs[k].s; int_in = vecs[k].i;
         longint_in = vecs[k].l; integer_in = vecs[k].g;
         exp_q.push_back(vecs[k]);
         tick();
      end
      idle_inputs();
      repeat (4) tick();
      @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      chk("table_pulses", sat_pulses, 14);
      chk("table_sample_count", s_sc, 14);
      sb_on = 0;

      // clear zeroes sums, counters and sticky overflow; in_ready drops while it is high
      tick();
      clear = 1;
      @(negedge clk);
      chk("clear_in_ready", s_in_ready, 0);
      tick();
      clear = 0;
      @(negedge clk);
      chk("clear_ovf", s_ovf, 0);
      chk("clear_byte", s_byte, 0);
      chk("clear_long", s_long, 0);
      chk("clear_sample_count", s_sc, 0);
      chk("clear_acc_valid", s_acc_valid, 0);
      chk("clear_in_ready_after", s_in_ready, 1);

      // enum histogram: A, C, D, C, 7
      do_reset();
      in_valid = 1;
      enum_in = 32'd0;      tick();
      enum_in = 32'd45;     tick();
      enum_in = 32'd123789; tick();
      enum_in = 32'd45;     tick();
      enum_in = 32'd7;      tick();
      idle_inputs();
      repeat (3) tick();
      @(negedge clk);
      chk("enum_a", s_ca, 1);
      chk("enum_b", s_cb, 0);
      chk("enum_c", s_cc, 2);
      chk("enum_d", s_cd, 1);
      chk("enum_invalid", s_ci, 1);
      chk("enum_samples", s_sc, 5);

      // 4-state sample is skipped by integer_acc (a 2-state simulator sees plain bits)
      do_reset();
      xv  = 32'h0000_00x1;
      is4 = $isunknown(xv);
      in_valid = 1;
      integer_in = xv; tick();
      integer_in = 32'd5; tick();
      idle_inputs();
      repeat (3) tick();
      @(negedge clk);
      chk("xz_integer_acc", s_integer, is4 ? 64'd5 : 64'(xv + 32'd5));
      chk("xz_count", s_xz, is4 ? 64'd1 : 64'd0);

      // latency: accepted at edge k, visible after edge k+1
      do_reset();
      in_valid = 1; byte_in = 8'd3;
      tick();
      idle_inputs();
      @(negedge clk);
      chk("lat_acc_valid_k", s_acc_valid, 0);
      chk("lat_sample_count", s_sc, 1);
      tick();
      @(negedge clk);
      chk("lat_acc_valid_k1", s_acc_valid, 1);
      chk("lat_byte", s_byte, 3);
      tick();
      @(negedge clk);
      chk("lat_acc_valid_pulse", s_acc_valid, 0);

      // rst with a sample in stage 1
      do_reset();
      sat_pulses = 0;
      in_valid = 1; byte_in = 8'd9;
      tick();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_mid_pulses", sat_pulses, 0);
      chk("rst_mid_byte", s_byte, 0);

      // clear in the cycle after an accept drops that sample
      do_reset();
      sat_pulses = 0;
      in_valid = 1; byte_in = 8'd11;
      tick();
      idle_inputs();
      clear = 1;
      tick();
      clear = 0;
      repeat (3) tick();
      @(negedge clk);
      chk("clr_mid_pulses", sat_pulses, 0);
      chk("clr_mid_byte", s_byte, 0);
      chk("clr_mid_samples", s_sc, 0);

      // COUNT_W=4: FULL after the 15th accept
      do_reset();
      cw4_pulses = 0;
      in_valid = 1;
      repeat (14) tick();
      @(negedge clk);
      chk("cw4_ready_at_14", c_in_ready, 1);
      tick();
      @(negedge clk);
      chk("cw4_ready_at_15", c_in_ready, 0);
      chk("cw4_samples", c_sc, 15);
      repeat (2) tick();
      idle_inputs();
      repeat (3) tick();
      @(negedge clk);
      chk("cw4_pulses", cw4_pulses, 15);
      chk("cw4_count_a", c_ca, 15);
      chk("cw4_still_full", c_in_ready, 0);
      tick();
      clear = 1;
      tick();
      clear = 0;
      @(negedge clk);
      chk("cw4_clear_ready", c_in_ready, 1);
      chk("cw4_clear_samples", c_sc, 0);
      chk("cw4_clear_count_a", c_ca, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
